count_step_monitor: RTL and testbench

- Downstream consumer of the structural 4-bit up-counter output.
- Runs on the undivided system clock and samples the 4-bit count every cycle.
- Emits one-cycle pulses on each legal increment and on each 15->0 wrap, and keeps a running wrap count.
- Detects illegal jumps, latches a sticky error, and holds it until software clears it and the monitor re-arms.

---
 rtl/count_step_monitor.sv | 106 ++++++++++
 tb/tb_count_step_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_step_monitor.sv
// count_step_monitor: watches a 4-bit up-counter stream, pulses on legal steps/wraps, flags illegal jumps.
// Optional WRAP_SATURATE_EN: wrap_cnt saturates at all-ones instead of rolling over.
//
// state | meaning
// ARM   | first sample after reset or clear; captures prev, no check
// TRACK | each sample must equal prev (hold) or prev+1 mod MAX_VAL+1 (step)
// ERROR | sticky error; pulses off, wrap_cnt frozen, waits for clr_err
module count_step_monitor #(
  parameter int WRAP_W  = 8,
  parameter int MAX_VAL = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [3:0]        count_in,
  input  logic              clr_err,
  output logic              step_pulse,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [1:0]        state_o
);

  localparam logic [1:0] ST_ARM   = 2'b00;
  localparam logic [1:0] ST_TRACK = 2'b01;
  localparam logic [1:0] ST_ERROR = 2'b10;
  localparam logic [3:0] MAX_V    = 4'(MAX_VAL);

  logic [1:0]        state_q, state_d;
  logic [3:0]        prev_q;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              err_q, err_d;
  logic [3:0]        inc;
  logic [WRAP_W-1:0] wrap_cnt_inc;

  assign inc = (prev_q == MAX_V) ? 4'd0 : prev_q + 4'd1;

`ifdef WRAP_SATURATE_EN
  assign wrap_cnt_inc = (wrap_cnt_q == {WRAP_W{1'b1}}) ? wrap_cnt_q : wrap_cnt_q + 1'b1;
`else
  assign wrap_cnt_inc = wrap_cnt_q + 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    step_d     = 1'b0;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    err_d      = err_q;
    case (state_q)
      ST_ARM: state_d = ST_TRACK;
      ST_TRACK: begin
        // values above MAX_VAL are illegal even if they match prev
        if (count_in > MAX_V) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else if (count_in == prev_q) begin
          state_d = ST_TRACK;
        end else if (count_in == inc) begin
          step_d = 1'b1;
          if (prev_q == MAX_V) begin
            wrap_d     = 1'b1;
            wrap_cnt_d = wrap_cnt_inc;
          end
        end else begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        if (clr_err) begin
          err_d      = 1'b0;
          wrap_cnt_d = '0;
          state_d    = ST_ARM;
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_ARM;
      prev_q     <= 4'd0;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= count_in;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_q      <= err_d;
    end
  end

  assign step_pulse = step_q;
  assign wrap_pulse = wrap_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign err        = err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_count_step_monitor.sv
// Bench for count_step_monitor: a behavioural model pushes expected outputs per edge, compared after the edge.
module tb_count_step_monitor;

  logic       clk;
  logic       rstn;
  logic [3:0] count_in;
  logic       clr_err;
  logic       step_pulse;
  logic       wrap_pulse;
  logic [7:0] wrap_cnt;
  logic       err;
  logic [1:0] state_o;

  count_step_monitor #(.WRAP_W(8), .MAX_VAL(15)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .count_in   (count_in),
    .clr_err    (clr_err),
    .step_pulse (step_pulse),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt),
    .err        (err),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       step;
    logic       wrap;
    logic [7:0] cnt;
    logic       err;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_step   = 0;
  int   n_wrap   = 0;

  // reference model
  logic [1:0] m_st;
  logic [3:0] m_prev;
  logic [7:0] m_cnt;
  logic       m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 2'd0; m_prev = 4'd0; m_cnt = 8'd0; m_err = 1'b0;
  endtask

  task automatic tick(input logic [3:0] c, input logic clr);
    exp_t e;
    exp_t got;
    @(negedge clk);
    count_in = c;
    clr_err  = clr;
    e = '0;
    if (m_st == 2'd0) begin
      m_st = 2'd1;
    end else if (m_st == 2'd1) begin
      if (c == m_prev) begin
      end else if ({1'b0, c} == ({1'b0, m_prev} + 5'd1) % 5'd16) begin
        e.step = 1'b1;
        if (m_prev == 4'd15) begin
          e.wrap = 1'b1;
`ifdef WRAP_SATURATE_EN
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
`else
          m_cnt = m_cnt + 8'd1;
`endif
        end
      end else begin
        m_err = 1'b1;
        m_st  = 2'd2;
      end
    end else if (clr) begin
      m_err = 1'b0;
      m_cnt = 8'd0;
      m_st  = 2'd0;
    end
    m_prev = c;
    e.cnt = m_cnt;
    e.err = m_err;
    e.st  = m_st;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    got = '{step_pulse, wrap_pulse, wrap_cnt, err, state_o};
    if (step_pulse) n_step++;
    if (wrap_pulse) n_wrap++;
    check("step_pulse", 32'(got.step), 32'(e.step));
    check("wrap_pulse", 32'(got.wrap), 32'(e.wrap));
    check("wrap_cnt",   32'(got.cnt),  32'(e.cnt));
    check("err",        32'(got.err),  32'(e.err));
    check("state_o",    32'(got.st),   32'(e.st));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_step"},  32'(step_pulse), 0);
    check({tag, "_wrap"},  32'(wrap_pulse), 0);
    check({tag, "_cnt"},   32'(wrap_cnt),   0);
    check({tag, "_err"},   32'(err),        0);
    check({tag, "_state"}, 32'(state_o),    0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    count_in = 4'd0;
    clr_err = 1'b0;
    model_reset();
    #1;
    check_zero("rst");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic run_to(input logic [3:0] v);
    for (int i = 1; i <= int'(v); i++) tick(4'(i), 1'b0);
  endtask

  initial begin
    rstn = 1'b0;
    count_in = 4'd0;
    clr_err = 1'b0;
    model_reset();
    #2;
    check_zero("por");

    // full sweep, each value held 4 clks
    do_reset();
    for (int i = 0; i < 3; i++) tick(4'd0, 1'b0);
    n_step = 0; n_wrap = 0;
    for (int v = 1; v <= 16; v++)
      for (int h = 0; h < 4; h++) tick(4'(v % 16), 1'b0);
    check("sweep_steps", 32'(n_step), 16);
    check("sweep_wraps", 32'(n_wrap), 1);
    check("sweep_cnt",   32'(wrap_cnt), 1);
    check("sweep_err",   32'(err), 0);

    // 256 full wraps
    do_reset();
    tick(4'd0, 1'b0);
    for (int w = 0; w < 256; w++)
      for (int v = 1; v <= 16; v++) tick(4'(v % 16), 1'b0);
`ifdef WRAP_SATURATE_EN
    check("wrap256_cnt", 32'(wrap_cnt), 255);
`else
    check("wrap256_cnt", 32'(wrap_cnt), 0);
`endif

    // skip 5->7, then 7->8 gives nothing
    do_reset();
    tick(4'd0, 1'b0);
    for (int v = 1; v <= 16; v++) tick(4'(v % 16), 1'b0);
    run_to(4'd5);
    tick(4'd7, 1'b0);
    check("skip_err",   32'(err), 1);
    check("skip_state", 32'(state_o), 2);
    check("skip_cnt",   32'(wrap_cnt), 1);
    tick(4'd8, 1'b0);
    check("skip_nostep", 32'(step_pulse), 0);

    // clear with count 8, re-arm, then 8->9
    tick(4'd8, 1'b1);
    check("clr_state", 32'(state_o), 0);
    check("clr_cnt",   32'(wrap_cnt), 0);
    tick(4'd8, 1'b0);
    check("rearm_state", 32'(state_o), 1);
    tick(4'd9, 1'b0);
    check("rearm_step", 32'(step_pulse), 1);

    // async reset mid-count at count 12, wrap_cnt 3
    do_reset();
    tick(4'd0, 1'b0);
    for (int w = 0; w < 3; w++)
      for (int v = 1; v <= 16; v++) tick(4'(v % 16), 1'b0);
    run_to(4'd12);
    tick(4'd12, 1'b0);
    check("pre_rst_cnt", 32'(wrap_cnt), 3);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_zero("async");
    @(negedge clk);
    count_in = 4'd0;
    #1;
    rstn = 1'b1;
    tick(4'd0, 1'b0);
    check("post_rst_state", 32'(state_o), 1);
    tick(4'd0, 1'b0);
    check("post_rst_err", 32'(err), 0);

    // decrement 3->2
    run_to(4'd3);
    tick(4'd2, 1'b0);
    check("dec_err", 32'(err), 1);

    // hold 9 for 20 clks after re-arm
    tick(4'd9, 1'b1);
    tick(4'd9, 1'b0);
    n_step = 0; n_wrap = 0;
    for (int i = 0; i < 20; i++) tick(4'd9, 1'b0);
    check("hold_steps", 32'(n_step), 0);
    check("hold_err",   32'(err), 0);
    check("hold_state", 32'(state_o), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
